// File: rtl/cpu_phase_sequencer.sv
// Single-clock N-phase instruction sequencer: per-block enable strobes, stall, run/idle, counters.
// Optional single-step (HALT state, step_mode/step inputs) under PHASE_SINGLE_STEP_EN.
module cpu_phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int IMEM_PHASE = 0,
  parameter int PROC_PHASE = 1,
  parameter int DMEM_PHASE = 2,
  parameter int RF_PHASE   = 3,
  parameter int CNT_W      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          stall_req,
`ifdef PHASE_SINGLE_STEP_EN
  input  logic                          step_mode,
  input  logic                          step,
`endif
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic                          imem_en,
  output logic                          proc_en,
  output logic                          dmem_en,
  output logic                          regfile_en,
  output logic                          instr_done,
  output logic                          busy,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [CNT_W-1:0]              retired_count
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam int NUM_EN = 4;
  localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);
  localparam int EN_PH [NUM_EN] = '{IMEM_PHASE, PROC_PHASE, DMEM_PHASE, RF_PHASE};

  generate
    if (NUM_PHASES < 2 || IMEM_PHASE >= NUM_PHASES || PROC_PHASE >= NUM_PHASES ||
        DMEM_PHASE >= NUM_PHASES || RF_PHASE >= NUM_PHASES) begin : g_bad_param
      $error("cpu_phase_sequencer: NUM_PHASES must be >= 2 and every phase index < NUM_PHASES");
    end
  endgenerate

`ifdef PHASE_SINGLE_STEP_EN
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t state;
  logic   advance;
  logic [NUM_EN-1:0] en;

  assign advance = (state == RUN) && !stall_req;

  for (genvar g = 0; g < NUM_EN; g++) begin : g_en
    assign en[g] = advance && (phase == PW'(EN_PH[g]));
  end

  assign imem_en    = en[0];
  assign proc_en    = en[1];
  assign dmem_en    = en[2];
  assign regfile_en = en[3];
  assign instr_done = advance && (phase == LAST);
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      phase         <= '0;
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (busy)       cycle_count   <= cycle_count + CNT_W'(1);
      if (instr_done) retired_count <= retired_count + CNT_W'(1);
      case (state)
        IDLE: begin
          phase <= '0;
          if (run) begin
`ifdef PHASE_SINGLE_STEP_EN
            state <= step_mode ? HALT : RUN;
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          if (!stall_req) begin
            if (phase == LAST) begin
              // Instruction boundary: the only point where run or step_mode take effect.
              phase <= '0;
              if (!run) state <= IDLE;
`ifdef PHASE_SINGLE_STEP_EN
              else if (step_mode) state <= HALT;
`endif
            end else begin
              phase <= phase + PW'(1);
            end
          end
        end
`ifdef PHASE_SINGLE_STEP_EN
        HALT: begin
          phase <= '0;
          if (!run) state <= IDLE;
          else if (!step_mode || step) state <= RUN;
        end
`endif
        default: begin
          state <= IDLE;
          phase <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench: vector table on the default config, plus sequences for 5 phases, 4-bit counters, reset and stepping.
module tb_cpu_phase_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic run0 = 1'b0, stall0 = 1'b0, run5 = 1'b0, run4 = 1'b0, stall_off = 1'b0;
  logic step_mode = 1'b0, step = 1'b0;

  logic [1:0]  ph0;  logic im0, pr0, dm0, rf0, dn0, bz0; logic [31:0] cy0, rt0;
  logic [2:0]  ph5;  logic im5, pr5, dm5, rf5, dn5, bz5; logic [31:0] cy5, rt5;
  logic [1:0]  ph4;  logic im4, pr4, dm4, rf4, dn4, bz4; logic [3:0]  cy4, rt4;

  int n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  cpu_phase_sequencer dut0 (
    .clock(clock), .reset(reset), .run(run0), .stall_req(stall0),
`ifdef PHASE_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .phase(ph0), .imem_en(im0), .proc_en(pr0), .dmem_en(dm0), .regfile_en(rf0),
    .instr_done(dn0), .busy(bz0), .cycle_count(cy0), .retired_count(rt0));

  cpu_phase_sequencer #(.NUM_PHASES(5), .RF_PHASE(4)) dut5 (
    .clock(clock), .reset(reset), .run(run5), .stall_req(stall_off),
`ifdef PHASE_SINGLE_STEP_EN
    .step_mode(stall_off), .step(stall_off),
`endif
    .phase(ph5), .imem_en(im5), .proc_en(pr5), .dmem_en(dm5), .regfile_en(rf5),
    .instr_done(dn5), .busy(bz5), .cycle_count(cy5), .retired_count(rt5));

  cpu_phase_sequencer #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .run(run4), .stall_req(stall_off),
`ifdef PHASE_SINGLE_STEP_EN
    .step_mode(stall_off), .step(stall_off),
`endif
    .phase(ph4), .imem_en(im4), .proc_en(pr4), .dmem_en(dm4), .regfile_en(rf4),
    .instr_done(dn4), .busy(bz4), .cycle_count(cy4), .retired_count(rt4));

  typedef struct {
    logic       run, stall;
    logic [1:0] ph;
    logic [4:0] en;   // {imem, proc, dmem, rf, done}
    logic       busy;
    int         cyc, ret;
  } vec_t;

  localparam int NV = 24;
  vec_t tv [NV];

  function automatic vec_t mk(logic r, logic s, logic [1:0] p, logic [4:0] e, logic b, int c, int t);
    vec_t v;
    v.run = r; v.stall = s; v.ph = p; v.en = e; v.busy = b; v.cyc = c; v.ret = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int dones, strobes;
    // Reset idle, start, one instruction, stall x3 at phase 2, run drop at phase 1, run toggle mid-instruction.
    tv[0]  = mk(0, 0, 0, 5'b00000, 0,  0, 0);
    tv[1]  = mk(1, 0, 0, 5'b00000, 0,  0, 0);
    tv[2]  = mk(1, 0, 0, 5'b10000, 1,  0, 0);
    tv[3]  = mk(1, 0, 1, 5'b01000, 1,  1, 0);
    tv[4]  = mk(1, 0, 2, 5'b00100, 1,  2, 0);
    tv[5]  = mk(1, 0, 3, 5'b00011, 1,  3, 0);
    tv[6]  = mk(1, 0, 0, 5'b10000, 1,  4, 1);
    tv[7]  = mk(1, 0, 1, 5'b01000, 1,  5, 1);
    tv[8]  = mk(1, 1, 2, 5'b00000, 1,  6, 1);
    tv[9]  = mk(1, 1, 2, 5'b00000, 1,  7, 1);
    tv[10] = mk(1, 1, 2, 5'b00000, 1,  8, 1);
    tv[11] = mk(1, 0, 2, 5'b00100, 1,  9, 1);
    tv[12] = mk(1, 0, 3, 5'b00011, 1, 10, 1);
    tv[13] = mk(1, 0, 0, 5'b10000, 1, 11, 2);
    tv[14] = mk(0, 0, 1, 5'b01000, 1, 12, 2);
    tv[15] = mk(0, 0, 2, 5'b00100, 1, 13, 2);
    tv[16] = mk(0, 0, 3, 5'b00011, 1, 14, 2);
    tv[17] = mk(0, 0, 0, 5'b00000, 0, 15, 3);
    tv[18] = mk(1, 0, 0, 5'b00000, 0, 15, 3);
    tv[19] = mk(0, 0, 0, 5'b10000, 1, 15, 3);
    tv[20] = mk(1, 0, 1, 5'b01000, 1, 16, 3);
    tv[21] = mk(0, 0, 2, 5'b00100, 1, 17, 3);
    tv[22] = mk(0, 0, 3, 5'b00011, 1, 18, 3);
    tv[23] = mk(0, 0, 0, 5'b00000, 0, 19, 4);

    tick(); tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      run0 = tv[i].run; stall0 = tv[i].stall;
      #1;
      chk($sformatf("vec%0d_outs", i), {ph0, im0, pr0, dm0, rf0, dn0, bz0}, {tv[i].ph, tv[i].en, tv[i].busy});
      chk($sformatf("vec%0d_cycle", i), cy0, tv[i].cyc);
      chk($sformatf("vec%0d_retired", i), rt0, tv[i].ret);
      tick();
    end

    // Five phases with regfile on the last: done every fifth cycle, three instructions.
    run5 = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      if (i == 10) run5 = 1'b0;
      #1;
      chk($sformatf("p5_cyc%0d", i), {ph5, im5, pr5, dm5, rf5, dn5},
          {3'(i % 5), i % 5 == 0, i % 5 == 1, i % 5 == 2, i % 5 == 4, i % 5 == 4});
      tick();
    end
    chk("p5_busy_end", bz5, 1'b0);
    chk("p5_retired", rt5, 32'd3);
    chk("p5_cycle", cy5, 32'd15);

    // 4-bit counters wrap: 17 busy cycles leave cycle_count at 1, four instructions retired.
    run4 = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) tick();
    chk("w4_cycle", cy4, 4'd1);
    chk("w4_retired", rt4, 4'd4);
    chk("w4_phase", ph4, 2'd1);

    // Asynchronous reset at phase 2 clears everything within the cycle.
    run0 = 1'b1;
    tick(); tick(); tick();
    chk("rst_pre_dmem", {ph0, dm0}, {2'd2, 1'b1});
    #2 reset = 1'b0;
    #1;
    chk("rst_outs", {ph0, im0, pr0, dm0, rf0, dn0, bz0}, 8'h00);
    chk("rst_counters", {cy0, rt0}, 64'd0);
    chk("rst_w4_counters", {cy4, rt4, bz4}, 9'd0);
    run0 = 1'b0; run4 = 1'b0;
    tick();
    chk("rst_held_outs", {ph0, dn0, bz0, rt0}, 36'd0);
    reset = 1'b1;
    tick();
    chk("rst_release_idle", {bz0, cy0}, 33'd0);

`ifdef PHASE_SINGLE_STEP_EN
    step_mode = 1'b1; run0 = 1'b1;
    tick();
    #1;
    chk("halt_entry", {ph0, im0, bz0}, {2'd0, 1'b0, 1'b1});
    dones = 0; strobes = 0;
    for (int c = 0; c < 24; c++) begin
      step = (c == 2 || c == 12);
      #1;
      dones   += int'(dn0);
      strobes += int'(im0) + int'(pr0) + int'(dm0) + int'(rf0);
      tick();
    end
    step = 1'b0;
    #1;
    chk("step_dones", dones, 2);
    chk("step_strobes", strobes, 8);
    chk("step_halt_state", {ph0, im0, dn0, bz0}, {2'd0, 1'b0, 1'b0, 1'b1});
    chk("step_retired", rt0, 32'd2);
    run0 = 1'b0;
    tick();
    chk("step_exit_idle", bz0, 1'b0);
`else
    dones = 0; strobes = 0;
    chk("nostep_counts", {32'(dones), 32'(strobes)}, {32'(rt0), 32'(rt0)});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
